// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM with a registered read port.
// Supports per-requester exclusive locks for read-modify-write, bounded by a timeout.
module sram_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_req,
    input  logic                  i_a_we,
    input  logic                  i_a_lock,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    output logic                  o_a_gnt,
    output logic                  o_a_rvalid,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    input  logic                  i_b_req,
    input  logic                  i_b_we,
    input  logic                  i_b_lock,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    output logic                  o_b_gnt,
    output logic                  o_b_rvalid,
    output logic [DATA_WIDTH-1:0] o_b_rdata,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_lock_err
);

    // The lock counter only ever reaches LOCK_MAX-1 before the timeout fires.
    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

    state_t           state_r;
    state_t           state_s;
    side_t            rr_last_r;
    side_t            rr_last_s;
    logic [CNT_W-1:0] lock_cnt_r;
    logic [CNT_W-1:0] lock_cnt_s;
    logic             a_gnt_s;
    logic             b_gnt_s;
    logic             timeout_s;
    logic             a_rvalid_r;
    logic             b_rvalid_r;
    logic             lock_err_r;

    // Grant selection, lock tracking and next-state computation.
    always_comb begin
        state_s    = state_r;
        rr_last_s  = rr_last_r;
        lock_cnt_s = lock_cnt_r;
        a_gnt_s    = 1'b0;
        b_gnt_s    = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_a_req && (!i_b_req || (rr_last_r == SIDE_B))) begin
                    a_gnt_s = 1'b1;
                end else if (i_b_req) begin
                    b_gnt_s = 1'b1;
                end else begin
                    a_gnt_s = 1'b0;
                    b_gnt_s = 1'b0;
                end
                if (a_gnt_s) begin
                    rr_last_s = SIDE_A;
                    if (i_a_lock) begin
                        state_s    = LOCK_A;
                        lock_cnt_s = CNT_W'(1);
                    end else begin
                        state_s = IDLE;
                    end
                end else if (b_gnt_s) begin
                    rr_last_s = SIDE_B;
                    if (i_b_lock) begin
                        state_s    = LOCK_B;
                        lock_cnt_s = CNT_W'(1);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOCK_A: begin
                a_gnt_s = i_a_req;
                if (!i_a_lock) begin
                    state_s    = IDLE;
                    lock_cnt_s = '0;
                end else if (lock_cnt_r == CNT_LAST) begin
                    // Owner held too long: force release so B wins the next tie.
                    state_s    = IDLE;
                    lock_cnt_s = '0;
                    timeout_s  = 1'b1;
                    rr_last_s  = SIDE_A;
                end else begin
                    lock_cnt_s = lock_cnt_r + CNT_W'(1);
                end
            end
            LOCK_B: begin
                b_gnt_s = i_b_req;
                if (!i_b_lock) begin
                    state_s    = IDLE;
                    lock_cnt_s = '0;
                end else if (lock_cnt_r == CNT_LAST) begin
                    state_s    = IDLE;
                    lock_cnt_s = '0;
                    timeout_s  = 1'b1;
                    rr_last_s  = SIDE_B;
                end else begin
                    lock_cnt_s = lock_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                lock_cnt_s = '0;
            end
        endcase
    end

    // SRAM port mux: the granted requester drives the macro, otherwise everything is zero.
    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (a_gnt_s) begin
            o_mem_we    = i_a_we;
            o_mem_addr  = i_a_addr;
            o_mem_wdata = i_a_wdata;
        end else if (b_gnt_s) begin
            o_mem_we    = i_b_we;
            o_mem_addr  = i_b_addr;
            o_mem_wdata = i_b_wdata;
        end else begin
            o_mem_we    = 1'b0;
            o_mem_addr  = '0;
            o_mem_wdata = '0;
        end
    end

    // State, round-robin pointer, lock counter and registered response flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= IDLE;
            rr_last_r  <= SIDE_B;
            lock_cnt_r <= '0;
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
            lock_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            rr_last_r  <= rr_last_s;
            lock_cnt_r <= lock_cnt_s;
            a_rvalid_r <= a_gnt_s & ~i_a_we;
            b_rvalid_r <= b_gnt_s & ~i_b_we;
            lock_err_r <= timeout_s;
        end
    end

    assign o_a_gnt    = a_gnt_s;
    assign o_b_gnt    = b_gnt_s;
    assign o_a_rvalid = a_rvalid_r;
    assign o_b_rvalid = b_rvalid_r;
    assign o_lock_err = lock_err_r;
    // Both requesters see the macro output; rvalid says whose it is.
    assign o_a_rdata  = i_mem_rdata;
    assign o_b_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter: directed scenarios plus randomized traffic
// compared against an ownership/turn-based reference model and a shadow memory.
module tb_sram_rr_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LM = 16;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, a_lock, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_we, lock_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    sram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_lock(a_lock), .i_a_addr(a_addr),
        .i_a_wdata(a_wdata), .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_lock(b_lock), .i_b_addr(b_addr),
        .i_b_wdata(b_wdata), .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_lock_err(lock_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fill_word(input int i);
        return (DW'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // SRAM macro: registered read, write lands at the edge.
    logic          fill = 1'b1;
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] <= fill_word(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            mem_rdata <= sram[mem_addr];
        end
    end

    // Reference model: who owns the memory, whose turn it is, how long a lock has lasted.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            owner = -1;
    int            last  = 1;
    int            held  = 0;
    bit            err_pend = 1'b0, pv_a = 1'b0, pv_b = 1'b0;
    logic [DW-1:0] pdata = '0;
    int            win = -1;
    bit            e_we, e_rv_a, e_rv_b, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;

    task automatic settle();
        @(negedge clk);
        if (owner == 0)               win = a_req ? 0 : -1;
        else if (owner == 1)          win = b_req ? 1 : -1;
        else if (a_req && b_req)      win = 1 - last;
        else if (a_req)               win = 0;
        else if (b_req)               win = 1;
        else                          win = -1;
        e_we    = (win == 0) ? a_we    : (win == 1) ? b_we    : 1'b0;
        e_addr  = (win == 0) ? a_addr  : (win == 1) ? b_addr  : '0;
        e_wdata = (win == 0) ? a_wdata : (win == 1) ? b_wdata : '0;
        e_rv_a  = pv_a;
        e_rv_b  = pv_b;
        e_rdata = pdata;
        e_err   = err_pend;
    endtask

    task automatic tick();
        @(posedge clk);
        if (win >= 0 && !e_we) pdata = shadow[e_addr];
        if (win >= 0 && e_we)  shadow[e_addr] = e_wdata;
        if (rst) begin
            owner = -1; last = 1; held = 0; err_pend = 1'b0; pv_a = 1'b0; pv_b = 1'b0;
        end else begin
            pv_a = (win == 0) && !e_we;
            pv_b = (win == 1) && !e_we;
            err_pend = 1'b0;
            if (owner >= 0) begin
                if (!((owner == 0) ? a_lock : b_lock)) owner = -1;
                else begin
                    held++;
                    if (held >= LM) begin err_pend = 1'b1; last = owner; owner = -1; end
                end
            end else if (win >= 0) begin
                last = win;
                if ((win == 0) ? a_lock : b_lock) begin owner = win; held = 1; end
            end
        end
        #1;
    endtask

    task automatic all_idle();
        a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        all_idle();
        settle(); tick();
        fill = 1'b0;
        settle(); tick();
        settle();
        checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", a_rvalid, b_rvalid); end
        checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL reset_lock_err: got %b want 0", lock_err); end
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_idle: gnt %b%b we %b want 000", a_gnt, b_gnt, mem_we); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        settle();
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL single_gnt: got %b%b want 10", a_gnt, b_gnt); end
        checks++; if (mem_addr !== 8'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL single_mem: addr %h we %b want 10 0", mem_addr, mem_we); end
        tick();
        a_req = 1'b0;
        settle();
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== fill_word(16)) begin errors++; $display("FAIL single_rdata: v %b d %h want 1 %h", a_rvalid, a_rdata, fill_word(16)); end
        tick();
    endtask

    task automatic test_write_read();
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 32'hDEAD_BEEF;
        settle();
        checks++; if (a_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_issue: gnt %b we %b wd %h", a_gnt, mem_we, mem_wdata); end
        tick();
        a_req = 1'b0; a_we = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
        settle();
        checks++; if (b_gnt !== 1'b1 || a_rvalid !== 1'b0) begin errors++; $display("FAIL wr_then_rd: b_gnt %b a_rvalid %b want 1 0", b_gnt, a_rvalid); end
        tick();
        b_req = 1'b0;
        settle();
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_after_wr: v %b d %h want 1 deadbeef", b_rvalid, b_rdata); end
        tick();
    endtask

    task automatic test_alternate();
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'($urandom_range(0, 255));
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            settle();
            checks++; if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin errors++; $display("FAIL alternate[%0d]: got %b%b want %b%b", i, a_gnt, b_gnt, i % 2 == 0, i % 2 == 1); end
            if (e_rv_a || e_rv_b) begin
                checks++; if (a_rvalid !== e_rv_a || b_rvalid !== e_rv_b || a_rdata !== e_rdata) begin errors++; $display("FAIL alt_resp[%0d]: v %b%b d %h want %b%b %h", i, a_rvalid, b_rvalid, a_rdata, e_rv_a, e_rv_b, e_rdata); end
            end
            tick();
            if (win == 0) a_addr = 8'($urandom_range(0, 255));
            else          b_addr = 8'($urandom_range(0, 255));
        end
        all_idle();
        settle();
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== e_rdata) begin errors++; $display("FAIL alt_last_resp: v %b d %h want 1 %h", b_rvalid, b_rdata, e_rdata); end
        tick();
    endtask

    task automatic test_lock_b();
        logic [DW-1:0] old;
        b_req = 1'b1; b_we = 1'b0; b_lock = 1'b1; b_addr = 8'h30;
        settle();
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL lock_b_acquire: got %b want 1", b_gnt); end
        tick();
        old = shadow[8'h30];
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h30;
        b_we = 1'b1; b_wdata = old + 32'd1;
        settle();
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== old) begin errors++; $display("FAIL lock_b_read: v %b d %h want 1 %h", b_rvalid, b_rdata, old); end
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin errors++; $display("FAIL lock_b_excl: got %b%b want 01", a_gnt, b_gnt); end
        tick();
        b_req = 1'b0; b_lock = 1'b0; b_we = 1'b0;
        settle();
        checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL lock_b_release_cycle: a_gnt %b want 0", a_gnt); end
        tick();
        settle();
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL lock_b_after: a_gnt %b want 1", a_gnt); end
        tick();
        a_req = 1'b0;
        settle();
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== old + 32'd1) begin errors++; $display("FAIL lock_b_rmw: v %b d %h want 1 %h", a_rvalid, a_rdata, old + 32'd1); end
        tick();
    endtask

    task automatic test_timeout();
        int err_cnt = 0, err_cyc = -1, first_b = -1;
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b1; a_addr = 8'h44;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin b_req = 1'b1; b_we = 1'b0; b_addr = 8'h55; end
            settle();
            checks++; if (a_gnt !== (win == 0) || b_gnt !== (win == 1) || lock_err !== e_err) begin errors++; $display("FAIL timeout_cyc[%0d]: gnt %b%b err %b want %b%b %b", i, a_gnt, b_gnt, lock_err, win == 0, win == 1, e_err); end
            if (lock_err === 1'b1) begin err_cnt++; err_cyc = i; end
            if (b_gnt === 1'b1 && first_b < 0) first_b = i;
            tick();
        end
        checks++; if (err_cnt != 1 || err_cyc != 16) begin errors++; $display("FAIL timeout_pulse: count %0d at %0d want 1 at 16", err_cnt, err_cyc); end
        checks++; if (first_b != 16) begin errors++; $display("FAIL timeout_b_next: first b gnt %0d want 16", first_b); end
        all_idle();
        settle(); tick();
        settle(); tick();
    endtask

    task automatic test_reset_mid();
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h50;
        settle(); tick();
        rst = 1'b1; a_addr = 8'h51;
        settle();
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt: got %b want 1", a_gnt); end
        tick();
        rst = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h52;
        settle();
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid: got %b want 0", a_rvalid); end
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL rst_mid_tie: got %b%b want 10", a_gnt, b_gnt); end
        tick();
        all_idle();
        settle(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!a_req || win == 0) begin
                a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
                a_addr = 8'($urandom_range(0, 7)); a_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) a_req = 1'b0;
            if (!b_req || win == 1) begin
                b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
                b_addr = 8'($urandom_range(0, 7)); b_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) b_req = 1'b0;
            if ($urandom_range(0, 9) == 0) a_lock = ~a_lock;
            if ($urandom_range(0, 9) == 0) b_lock = ~b_lock;
            settle();
            checks++;
            if (a_gnt !== (win == 0) || b_gnt !== (win == 1) || mem_we !== e_we
                || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                errors++;
                $display("FAIL rand_issue[%0d]: gnt %b%b we %b a %h d %h want %b%b %b %h %h", i,
                         a_gnt, b_gnt, mem_we, mem_addr, mem_wdata, win == 0, win == 1, e_we, e_addr, e_wdata);
            end
            checks++;
            if (a_rvalid !== e_rv_a || b_rvalid !== e_rv_b || lock_err !== e_err
                || ((e_rv_a || e_rv_b) && mem_rdata !== e_rdata)) begin
                errors++;
                $display("FAIL rand_resp[%0d]: v %b%b err %b d %h want %b%b %b %h", i,
                         a_rvalid, b_rvalid, lock_err, mem_rdata, e_rv_a, e_rv_b, e_err, e_rdata);
            end
            tick();
        end
        all_idle();
        settle(); tick();
        settle(); tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) shadow[i] = fill_word(i);
        test_reset();
        test_single_read();
        test_write_read();
        test_alternate();
        test_lock_b();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
